// File: rtl/pipe_mux_pkg.sv
// pipe_mux_pkg: shared helpers and types for the pipe_mux_n slice.
//   sel_width(n) : select width for an n-way mux, $clog2(n) but never below 1.
//   mux_beat_t   : {err, data} beat layout at the default data width. The top
//                  module declares the same layout locally at its own width W.
// Optional feature macro used by this slice: MUX_SKID_EN (see pipe_mux_skid).
package pipe_mux_pkg;

    localparam int MUX_DEF_W = 32;

    function automatic int sel_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    typedef struct packed {
        logic                 err;
        logic [MUX_DEF_W-1:0] data;
    } mux_beat_t;

endpackage

// File: rtl/pipe_mux_skid.sv
// pipe_mux_skid: generic DW-bit valid/ready register slice.
//   clk, rst              : clock, synchronous active-high reset
//   in_data/in_valid/in_ready    : upstream side
//   out_data/out_valid/out_ready : downstream side (registered)
// Macro MUX_SKID_EN: when defined, a one-entry skid register sits behind the
// output register and in_ready comes from a flop (no out_ready->in_ready path).
// When undefined, only the output register exists and in_ready is combinational.
module pipe_mux_skid #(
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic          in_ready_s;
    logic          accept_s;

    assign accept_s  = in_valid && in_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef MUX_SKID_EN

    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_data_q,  skid_data_d;
    logic          in_ready_q,   in_ready_d;
    logic          pop_s;

    // in_ready_q is 1 exactly when the skid is empty; reset masks it.
    assign in_ready_s = in_ready_q && !rst;
    assign pop_s      = out_valid_q && out_ready;

    // Next-state for the output register, skid entry and registered ready.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        in_ready_d   = in_ready_q;
        if (!out_valid_q) begin
            // Output empty implies skid empty: new beat goes straight out.
            if (accept_s) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (pop_s) begin
            if (skid_valid_q) begin
                // Skid full means in_ready was low, so no accept can coincide.
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
                in_ready_d   = 1'b1;
            end else if (accept_s) begin
                out_data_d = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            // Output stalled: a newly accepted beat parks in the skid.
            if (accept_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
                in_ready_d   = 1'b0;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // State registers; reset empties both entries and re-arms in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {DW{1'b0}};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {DW{1'b0}};
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

`else

    // Ready when the output register is free or is being drained this cycle.
    assign in_ready_s = !rst && (!out_valid_q || out_ready);

    // Next-state for the single output register.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`endif

endmodule

// File: rtl/pipe_mux_n.sv
// pipe_mux_n: registered N-way, W-bit multiplexer with valid/ready on both sides.
//   clk, rst    : clock, synchronous active-high reset
//   in_data     : N packed channels, channel k at [k*W +: W]
//   in_sel      : channel select, qualified by in_valid
//   in_valid/in_ready   : upstream handshake
//   out_data    : selected channel (zero when the select is out of range)
//   out_sel_err : select for this beat was >= N
//   out_valid/out_ready : downstream handshake
// Macro MUX_SKID_EN: adds a one-entry skid behind the output register and
// makes in_ready a flop.
module pipe_mux_n
    import pipe_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [SELW-1:0] in_sel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_sel_err,
    output logic            out_valid,
    input  logic            out_ready
);

    // Same layout as mux_beat_t, sized to this instance's W.
    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } beat_t;

    logic [N-1:0] sel_hit_s;
    beat_t        in_beat_s;
    logic [W:0]   out_vec_s;
    beat_t        out_beat_s;

    // One-hot select decode followed by an AND-OR mux. An out-of-range select
    // hits no channel, which yields zero data and raises err in one step.
    always_comb begin
        sel_hit_s      = {N{1'b0}};
        in_beat_s.data = {W{1'b0}};
        for (int k = 0; k < N; k++) begin
            sel_hit_s[k]   = (in_sel == SELW'(k));
            in_beat_s.data = in_beat_s.data | (in_data[k*W +: W] & {W{sel_hit_s[k]}});
        end
        in_beat_s.err = ~|sel_hit_s;
    end

    pipe_mux_skid #(
        .DW (W + 1)
    ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_beat_s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_vec_s),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_beat_s  = out_vec_s;
    assign out_data    = out_beat_s.data;
    assign out_sel_err = out_beat_s.err;

endmodule

// File: tb/tb_pipe_mux_n.sv
// tb_pipe_mux_n: scoreboard bench for pipe_mux_n. Two instances share clock and
// reset: d=0 is N=4 (streaming, stall, reset tests), d=1 is N=3 (out-of-range).
// Expected beats are pushed when an input transfer is seen; a monitor pops and
// compares on every output transfer and checks that stalled outputs hold.
module tb_pipe_mux_n;

    typedef struct {
        logic        err;
        logic [31:0] data;
        bit          lat;
        int          acc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [31:0]  chan [2][4];
    logic [1:0]   sel [2];
    logic         in_valid [2];
    logic         in_ready [2];
    logic [31:0]  out_data [2];
    logic         out_err [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] in_data0;
    logic [95:0]  in_data1;

    exp_t sb0[$];
    exp_t sb1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   stalled [2];
    logic [32:0] hold [2];
    bit   rdone [2];

    assign in_data0 = {chan[0][3], chan[0][2], chan[0][1], chan[0][0]};
    assign in_data1 = {chan[1][2], chan[1][1], chan[1][0]};

    pipe_mux_n #(.N(4), .W(32)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_sel(sel[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_data(out_data[0]),
        .out_sel_err(out_err[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0])
    );

    pipe_mux_n #(.N(3), .W(32)) u_dut3 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_sel(sel[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_data(out_data[1]),
        .out_sel_err(out_err[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: run exceeded its time budget, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: selected channel if the select names a real channel, else 0 + err.
    function automatic exp_t model(input int d, input logic [1:0] s);
        exp_t r;
        int   n;
        n      = (d == 0) ? 4 : 3;
        r.err  = (int'(s) >= n);
        r.data = (int'(s) < n) ? chan[d][s] : 32'd0;
        r.lat  = 1'b0;
        r.acc  = 0;
        return r;
    endfunction

    // Present one beat on side d and wait for it to be accepted.
    task automatic send(input int d, input logic [1:0] s, input bit lat, output int acc);
        bit   done;
        int   budget;
        exp_t e;
        done   = 1'b0;
        budget = 0;
        acc    = -1;
        sel[d]      = s;
        in_valid[d] = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready[d]) begin
                e     = model(d, s);
                e.lat = lat;
                e.acc = cyc;
                acc   = cyc;
                if (d == 0) sb0.push_back(e);
                else        sb1.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!done) begin
                budget = budget + 1;
                if (budget > 200) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL accept_timeout: side %0d not ready after %0d cycles", d, budget);
                    done = 1'b1;
                end
            end
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic drive_random(input int d, input int beats);
        int a;
        for (int i = 0; i < beats; i++) begin
            while ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < 4; k++) chan[d][k] = $urandom;
            send(d, 2'($urandom_range(0, 3)), 1'b0, a);
        end
        rdone[d] = 1'b1;
    endtask

    task automatic toggle_ready(input int d);
        while (!rdone[d]) begin
            @(posedge clk);
            #1;
            out_ready[d] = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: compare each output transfer against the scoreboard and check
    // that a stalled output keeps its value until it is taken.
    initial begin
        exp_t e;
        bit   empty;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    stalled[d] = 1'b0;
                end else begin
                    if (stalled[d]) begin
                        check("hold_valid", 64'(out_valid[d]), 64'd1);
                        check("hold_beat", 64'({out_err[d], out_data[d]}), 64'(hold[d]));
                    end
                    if (out_valid[d] && out_ready[d]) begin
                        empty = 1'b0;
                        if (d == 0) begin
                            if (sb0.size() == 0) empty = 1'b1; else e = sb0.pop_front();
                        end else begin
                            if (sb1.size() == 0) empty = 1'b1; else e = sb1.pop_front();
                        end
                        if (empty) begin
                            total = total + 1;
                            bad   = bad + 1;
                            $display("FAIL spurious_beat: side %0d emitted 0x%0h with nothing expected",
                                     d, out_data[d]);
                        end else begin
                            check("beat", 64'({out_err[d], out_data[d]}), 64'({e.err, e.data}));
                            if (e.lat) check("latency", 64'(cyc), 64'(e.acc + 1));
                        end
                        stalled[d] = 1'b0;
                    end else if (out_valid[d]) begin
                        stalled[d] = 1'b1;
                        hold[d]    = {out_err[d], out_data[d]};
                    end else begin
                        stalled[d] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int acc [4];
        int a;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b1;
            out_ready[d] = 1'b1;
            sel[d]       = 2'd0;
            stalled[d]   = 1'b0;
            rdone[d]     = 1'b0;
            for (int k = 0; k < 4; k++) chan[d][k] = 32'h5A5A_0000 + 32'(k);
        end

        // Reset held for three edges with in_valid asserted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                check("rst_out_valid", 64'(out_valid[d]), 64'd0);
                check("rst_out_data", 64'(out_data[d]), 64'd0);
                check("rst_out_err", 64'(out_err[d]), 64'd0);
                check("rst_in_ready", 64'(in_ready[d]), 64'd0);
            end
        end
        rst = 1'b0;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("post_rst_in_ready", 64'(in_ready[d]), 64'd1);
        @(posedge clk);
        #1;

        // Streaming A0..A3 on consecutive cycles, one-cycle latency each.
        for (int k = 0; k < 4; k++) chan[0][k] = 32'hA0 + 32'(k);
        for (int k = 0; k < 4; k++) send(0, 2'(k), 1'b1, acc[k]);
        for (int k = 1; k < 4; k++) check("no_bubble", 64'(acc[k]), 64'(acc[0] + k));
        repeat (3) begin @(posedge clk); #1; end

        // Out-of-range select on the 3-way instance, then a legal select.
        for (int k = 0; k < 4; k++) chan[1][k] = 32'hFFFF_FFFF;
        send(1, 2'd3, 1'b1, a);
        check("oor_data", 64'(out_data[1]), 64'd0);
        check("oor_err", 64'(out_err[1]), 64'd1);
        send(1, 2'd1, 1'b1, a);
        check("inr_data", 64'(out_data[1]), 64'hFFFF_FFFF);
        check("inr_err", 64'(out_err[1]), 64'd0);
        repeat (3) begin @(posedge clk); #1; end

        // Stall: 0x11 held for five cycles with out_ready low.
        out_ready[0] = 1'b0;
        chan[0][0]   = 32'h11;
        send(0, 2'd0, 1'b0, a);
`ifdef MUX_SKID_EN
        chan[0][0] = 32'h22;
        send(0, 2'd0, 1'b0, a);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid[0]), 64'd1);
            check("stall_data", 64'(out_data[0]), 64'h11);
            check("stall_in_ready", 64'(in_ready[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("release_first", 64'({out_valid[0], out_data[0]}), {31'd0, 1'b1, 32'h11});
`ifdef MUX_SKID_EN
        @(negedge clk);
        check("release_second", 64'({out_valid[0], out_data[0]}), {31'd0, 1'b1, 32'h22});
`endif
        repeat (3) begin @(posedge clk); #1; end

        // Reset while beats are held: they must vanish.
        out_ready[0] = 1'b0;
        chan[0][2]   = 32'h33;
        send(0, 2'd2, 1'b0, a);
`ifdef MUX_SKID_EN
        chan[0][2] = 32'h44;
        send(0, 2'd2, 1'b0, a);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb0.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
        check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        chan[0][3]   = 32'h55;
        send(0, 2'd3, 1'b1, a);
        repeat (4) begin @(posedge clk); #1; end
        check("midrst_drained", 64'(sb0.size()), 64'd0);

        // Random valid/ready traffic on both instances.
        fork
            drive_random(0, 10000);
            drive_random(1, 2000);
            toggle_ready(0);
            toggle_ready(1);
        join
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("final_sb0_empty", 64'(sb0.size()), 64'd0);
        check("final_sb1_empty", 64'(sb1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
